// File: rtl/ex_muldiv_pkg.sv
// Shared types for the EX-stage RV32M multiply/divide unit: funct3 encodings,
// OP/funct7 decode constants, FSM states and small op-class helpers.
package ex_muldiv_pkg;

  localparam int XLEN = 32;

  // M-extension ops live under OP with funct7 = 0000001
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_funct3_t f);
    return f inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_funct3_t f);
    return f inside {F3_REM, F3_REMU};
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> muldiv bundle: op request from the pipeline, stall/done/result back.
// The pipeline (master) holds start until the op leaves EX; the unit (slave) stalls it.
interface ex_muldiv_if
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output stall, done, result
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M mul/div: radix-2 shift-add / restoring divide; done in cycle WIDTH+1, div fast paths in cycle 1.
// Backpressure: stall held from acceptance through the last iteration, released in the DONE cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
)(
  input logic        clk,
  input logic        reset,
  ex_muldiv_if.slave mdu
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t  state, state_n;
  muldiv_funct3_t op, op_in;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] hi, lo, opnd, result_q;
  logic             neg_q, neg_r;

  logic             accept, stall_c;
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, fast;
  logic [WIDTH-1:0] fast_res;

  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub, hi_n, lo_n, quo, rem;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   calc_res;

  assign op_in  = muldiv_funct3_t'(mdu.funct3);
  assign accept = (state == IDLE) && mdu.start && !mdu.flush;

  // Operand decode at acceptance: magnitudes, sign flags and divide fast paths
  always_comb begin
    a_signed = op_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed = op_in inside {F3_MULH, F3_DIV, F3_REM};
    a_neg    = a_signed && mdu.rs1[WIDTH-1];
    b_neg    = b_signed && mdu.rs2[WIDTH-1];
    a_mag    = a_neg ? -mdu.rs1 : mdu.rs1;
    b_mag    = b_neg ? -mdu.rs2 : mdu.rs2;
    div_zero = (mdu.rs2 == '0);
    div_ovf  = (op_in inside {F3_DIV, F3_REM}) &&
               (mdu.rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (mdu.rs2 == '1);
    fast     = is_div(op_in) && (div_zero || div_ovf);
    fast_res = '0;
    if (div_zero)
      fast_res = is_rem(op_in) ? mdu.rs1 : '1;
    else if (div_ovf)
      fast_res = is_rem(op_in) ? '0 : mdu.rs1;
  end

  // One radix-2 step; mul keeps {hi,lo} as product/multiplier, div as remainder/quotient
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_sub   = div_shift[WIDTH-1:0] - opnd;
    if (is_div(op)) begin
      hi_n = div_ge ? div_sub : div_shift[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], div_ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_n : lo_n;
    rem    = neg_r ? -hi_n : hi_n;
    case (op)
      F3_MUL:                       calc_res = prod_s[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod_s[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              calc_res = quo;
      default:                      calc_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall_c = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall_c = 1'b1;
        state_n = fast ? DONE : CALC;
      end
      CALC: begin
        stall_c = 1'b1;
        if (cnt == '0) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (mdu.flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op       <= F3_MUL;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op    <= op_in;
      cnt   <= CW'(WIDTH-1);
      hi    <= '0;
      lo    <= is_div(op_in) ? a_mag : b_mag;
      opnd  <= is_div(op_in) ? b_mag : a_mag;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (fast) result_q <= fast_res;
    end else if (state == CALC && !mdu.flush) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - CW'(1);
      if (cnt == '0) result_q <= calc_res;
    end
  end

  assign mdu.stall  = stall_c;
  assign mdu.done   = (state == DONE);
  assign mdu.result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: per-op latency, stall shape, results, fast paths,
// flush/reset mid-op and back-to-back issue.
module tb_ex_muldiv;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   last_done_cyc;

  ex_muldiv_if #(.WIDTH(32)) mdu ();

  ex_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op at the next negedge; start stays high until the caller changes it.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit stall_ok;
    @(negedge clk);
    mdu.start  = 1'b1;
    mdu.flush  = 1'b0;
    mdu.funct3 = f3;
    mdu.rs1    = a;
    mdu.rs2    = b;
    #1;
    check({tag, " stall@0"}, 32'(mdu.stall), 32'd1);
    check({tag, " done@0"}, 32'(mdu.done), 32'd0);
    lat      = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mdu.done) begin
        lat = c;
        last_done_cyc = cyc;
        break;
      end
      if (!mdu.stall) stall_ok = 1'b0;
      if (c == 2) begin
        mdu.rs1    = ~a;
        mdu.rs2    = ~b;
        mdu.funct3 = ~f3;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, mdu.result, exp_res);
    check({tag, " stall@done"}, 32'(mdu.stall), 32'd0);
    check({tag, " stall held"}, 32'(stall_ok), 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    mdu.start = 1'b0;
    mdu.flush = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    bit any_done;
    int d1;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    reset      = 1'b1;
    mdu.start  = 1'b0;
    mdu.flush  = 1'b0;
    mdu.funct3 = 3'b000;
    mdu.rs1    = 32'h0;
    mdu.rs2    = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset stall", 32'(mdu.stall), 32'd0);
    check("reset done", 32'(mdu.done), 32'd0);
    check("reset result", mdu.result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    idle(3);
    #1;
    check("result held", mdu.result, 32'hFFFF_FFEB);
    check("done after pulse", 32'(mdu.done), 32'd0);

    run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    idle(2);

    run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    idle(2);

    run_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU 5/0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    idle(2);

    // flush wins over start in IDLE: a fast-path op must not be accepted
    @(negedge clk);
    mdu.start  = 1'b1;
    mdu.flush  = 1'b1;
    mdu.funct3 = 3'b100;
    mdu.rs1    = 32'd5;
    mdu.rs2    = 32'd0;
    #1;
    check("flush+start stall", 32'(mdu.stall), 32'd0);
    @(negedge clk);
    mdu.start = 1'b0;
    mdu.flush = 1'b0;
    #1;
    check("flush+start no done", 32'(mdu.done), 32'd0);
    idle(2);

    // flush in cycle 10 of a DIV
    @(negedge clk);
    mdu.start  = 1'b1;
    mdu.funct3 = 3'b100;
    mdu.rs1    = 32'd100;
    mdu.rs2    = 32'd7;
    repeat (10) @(negedge clk);
    mdu.flush = 1'b1;
    mdu.start = 1'b0;
    @(negedge clk);
    mdu.flush = 1'b0;
    #1;
    check("flush done@11", 32'(mdu.done), 32'd0);
    check("flush stall@11", 32'(mdu.stall), 32'd0);
    any_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (mdu.done) any_done = 1'b1;
    end
    check("flush no done pulse", 32'(any_done), 32'd0);
    run_op("MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    idle(2);

    // reset in cycle 20 of a DIVU
    @(negedge clk);
    mdu.start  = 1'b1;
    mdu.funct3 = 3'b101;
    mdu.rs1    = 32'd100;
    mdu.rs2    = 32'd7;
    repeat (20) @(negedge clk);
    reset     = 1'b1;
    mdu.start = 1'b0;
    @(negedge clk);
    #1;
    check("reset mid done", 32'(mdu.done), 32'd0);
    check("reset mid result", mdu.result, 32'h0);
    check("reset mid stall", 32'(mdu.stall), 32'd0);
    reset    = 1'b0;
    any_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mdu.done) any_done = 1'b1;
    end
    check("reset no done pulse", 32'(any_done), 32'd0);

    // back-to-back issue on the cycle after DONE
    run_op("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 33);
    d1 = last_done_cyc;
    run_op("MUL 5*5", 3'b000, 32'd5, 32'd5, 32'd25, 33);
    check("b2b done spacing", 32'(last_done_cyc - d1), 32'd34);
    idle(1);
    #1;
    check("b2b pulse width", 32'(mdu.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
